// File: rtl/mul_div_seq_unit.sv
// ============================================================================
// Module   : mul_div_seq_unit
// Brief    : Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU (32x32->64).
//            Optional macro MUL_EARLY_OUT_EN short-circuits zero operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_seq_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  ALUContrl,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [4:0] C_OP_MUL    = 5'b10001;
    localparam logic [4:0] C_OP_MULH   = 5'b10010;
    localparam logic [4:0] C_OP_MULHSU = 5'b10011;
    localparam logic [4:0] C_OP_MULHU  = 5'b10100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q,  state_d;
    logic [63:0] mcand_q,  mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q,    acc_d;
    logic [5:0]  cnt_q,    cnt_d;
    logic        neg_q,    neg_d;
    logic        lo_q,     lo_d;
    logic [31:0] result_q, result_d;

    logic        w_accept;
    logic        w_s1_signed;
    logic        w_s2_signed;
    logic        w_s1_neg;
    logic        w_s2_neg;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [63:0] w_acc_fin;

    assign w_accept    = start && (ALUContrl >= C_OP_MUL) && (ALUContrl <= C_OP_MULHU);
    assign w_s1_signed = (ALUContrl == C_OP_MULH) || (ALUContrl == C_OP_MULHSU);
    assign w_s2_signed = (ALUContrl == C_OP_MULH);
    assign w_s1_neg    = w_s1_signed && src1[31];
    assign w_s2_neg    = w_s2_signed && src2[31];
    assign w_mag1      = w_s1_neg ? (~src1 + 32'd1) : src1;
    assign w_mag2      = w_s2_neg ? (~src2 + 32'd1) : src2;
    assign w_acc_fin   = neg_q ? (~acc_q + 64'd1) : acc_q;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        lo_d     = lo_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    mcand_d  = {32'd0, w_mag1};
                    mplier_d = w_mag2;
                    neg_d    = w_s1_neg ^ w_s2_neg;
                    lo_d     = (ALUContrl == C_OP_MUL);
                    acc_d    = 64'd0;
                    cnt_d    = 6'd0;
                    state_d  = S_CALC;
`ifdef MUL_EARLY_OUT_EN
                    if ((src1 == 32'd0) || (src2 == 32'd0)) begin
                        result_d = 32'd0;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = {mcand_q[62:0], 1'b0};
                mplier_d = {1'b0, mplier_q[31:1]};
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                acc_d    = w_acc_fin;
                result_d = lo_q ? w_acc_fin[31:0] : w_acc_fin[63:32];
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 6'd0;
            neg_q    <= 1'b0;
            lo_q     <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    // Outputs decode straight from registers, so nothing combinational reaches them.
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_seq_unit.sv
// ============================================================================
// Module   : tb_mul_div_seq_unit
// Brief    : Scoreboard bench for mul_div_seq_unit with hand-computed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_seq_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  ALUContrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests;
    int fails;
    int cyc;
    int done_seen;

    typedef struct {
        logic [31:0] res;
        int          n;
        int          d;
    } exp_t;

    exp_t sb[$];

    mul_div_seq_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ALUContrl (ALUContrl),
        .src1      (src1),
        .src2      (src2),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: busy is expected inside the head item's window; done pops the head.
    always @(negedge clk) begin
        logic exp_busy;
        exp_busy = (sb.size() > 0) && (cyc > sb[0].n) && (cyc <= sb[0].d);
        if (!rst) check("busy", {31'd0, busy}, {31'd0, exp_busy});
        if (done) begin
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("done_cycle", cyc, e.d);
            end
        end
    end

    task automatic issue(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        exp_t e;
        bit   early;
        early = 1'b0;
`ifdef MUL_EARLY_OUT_EN
        early = (a == 32'd0) || (b == 32'd0);
`endif
        @(negedge clk);
        e.res = exp;
        e.n   = cyc;
        e.d   = cyc + (early ? 1 : 34);
        sb.push_back(e);
        start = 1'b1; ALUContrl = code; src1 = a; src2 = b;
        @(posedge clk);
        #1;
        start = 1'b0; ALUContrl = 5'($urandom); src1 = $urandom; src2 = $urandom;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'd1, 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int ds;
        tests = 0; fails = 0; cyc = 0; done_seen = 0;
        rst = 1'b1; start = 1'b0; ALUContrl = 5'd0; src1 = 32'd0; src2 = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);

        issue(5'd17, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB); drain();
        issue(5'd18, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000); drain();
        issue(5'd18, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF); drain();
        issue(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); drain();
        issue(5'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); drain();
        issue(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001); drain();
        issue(5'd18, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFFF); drain();

        // Out-of-group code must leave the unit idle.
        ds = done_seen;
        @(negedge clk);
        start = 1'b1; ALUContrl = 5'b00000; src1 = 32'd9; src2 = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (40) @(negedge clk);
        check("bad_code_no_done", done_seen, ds);

        // A second start mid-operation is ignored.
        issue(5'd17, 32'd123, 32'd456, 32'h0000_DB18);
        repeat (5) @(negedge clk);
        start = 1'b1; ALUContrl = 5'd20; src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 start = 1'b0;
        drain();

        // Reset in cycle N+10 abandons the operation.
        issue(5'd17, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        ds = done_seen;
        @(negedge clk);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_result", result, 32'd0);
        repeat (40) @(negedge clk);
        check("rst_no_done", done_seen, ds);

        issue(5'd17, 32'd3, 32'd5, 32'h0000_000F); drain();
        issue(5'd20, 32'hABCD_EF01, 32'd0, 32'd0); drain();
        issue(5'd17, 32'd0, 32'h1234_5678, 32'd0); drain();
        issue(5'd20, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001); drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
